// File: rtl/sargantana_set_ram_ctrl_if.sv
// -----------------------------------------------------------------------------
// sargantana_set_ram_ctrl_if
// Bundle of the signals between the icache control FSM, the set RAM access
// controller and the set RAM pins.
//   lkp_*   : fetch lookup request (valid/ready) plus registered read-valid
//   rfl_*   : line refill write request (valid/ready)
//   flush_* : flush sweep start / busy / done
//   ram_*   : set RAM req/we/addr/data pins driven by the controller
// Modports:
//   slave  : the controller view (sargantana_set_ram_ctrl)
//   master : the requester / RAM side view
// -----------------------------------------------------------------------------
interface sargantana_set_ram_ctrl_if #(
  parameter int SET_WIDHT  = 32*8,
  parameter int ADDR_WIDHT = 6
);
  logic                  lkp_valid_i;
  logic [ADDR_WIDHT-1:0] lkp_addr_i;
  logic                  lkp_ready_o;
  logic                  lkp_rvalid_o;

  logic                  rfl_valid_i;
  logic [ADDR_WIDHT-1:0] rfl_addr_i;
  logic [SET_WIDHT-1:0]  rfl_data_i;
  logic                  rfl_ready_o;

  logic                  flush_i;
  logic                  flush_busy_o;
  logic                  flush_done_o;

  logic                  ram_req_o;
  logic                  ram_we_o;
  logic [ADDR_WIDHT-1:0] ram_addr_o;
  logic [SET_WIDHT-1:0]  ram_data_o;

  modport slave (
    input  lkp_valid_i, lkp_addr_i,
    output lkp_ready_o, lkp_rvalid_o,
    input  rfl_valid_i, rfl_addr_i, rfl_data_i,
    output rfl_ready_o,
    input  flush_i,
    output flush_busy_o, flush_done_o,
    output ram_req_o, ram_we_o, ram_addr_o, ram_data_o
  );

  modport master (
    output lkp_valid_i, lkp_addr_i,
    input  lkp_ready_o, lkp_rvalid_o,
    output rfl_valid_i, rfl_addr_i, rfl_data_i,
    input  rfl_ready_o,
    output flush_i,
    input  flush_busy_o, flush_done_o,
    input  ram_req_o, ram_we_o, ram_addr_o, ram_data_o
  );
endinterface

// File: rtl/sargantana_set_ram_ctrl.sv
// -----------------------------------------------------------------------------
// sargantana_set_ram_ctrl
// Access controller for one icache set RAM (single port, 1-cycle synchronous
// read, either a write or a read per cycle). Arbitrates fetch lookups against
// line refills and sequences a full-array flush sweep (zero every entry).
//
// Ports:
//   clk_i   : clock, all state on posedge
//   rstn_i  : asynchronous active-low reset
//   bus     : sargantana_set_ram_ctrl_if.slave
//             lkp_valid_i/lkp_addr_i -> lkp_ready_o, lkp_rvalid_o (cycle after)
//             rfl_valid_i/rfl_addr_i/rfl_data_i -> rfl_ready_o
//             flush_i -> flush_busy_o, flush_done_o (1-cycle pulse)
//             ram_req_o/ram_we_o/ram_addr_o/ram_data_o to the RAM pins
//
// Optional feature macro: SARGANTANA_SET_RAM_CTRL_STARVE_GUARD_EN
//   defined   : after STARVE_LIMIT consecutive refill grants with a lookup
//               waiting, the next contended IDLE cycle grants the lookup
//   undefined : strict refill-over-lookup priority
//
// State | meaning
// ------+----------------------------------------------------------
// IDLE  | arbitrate flush_i > refill > lookup, grant same cycle
// FLUSH | write zero to entry cnt_q each cycle, 2**ADDR_WIDHT cycles
// -----------------------------------------------------------------------------
module sargantana_set_ram_ctrl #(
  parameter int SET_WIDHT    = 32*8,
  parameter int ADDR_WIDHT   = 6,
  parameter int STARVE_LIMIT = 4
) (
  input logic                      clk_i,
  input logic                      rstn_i,
  sargantana_set_ram_ctrl_if.slave bus
);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] FLUSH = 1'b1;

  localparam int                    SW    = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0]         LIMIT = SW'(STARVE_LIMIT);
  localparam logic [ADDR_WIDHT-1:0] LAST  = '1;

  logic [0:0]            state_q, state_d;
  logic [ADDR_WIDHT-1:0] cnt_q, cnt_d;
  logic                  done_q, done_d;
  logic                  rvalid_q, rvalid_d;
  logic [SW-1:0]         starve_q, starve_d;

  logic                  lkp_first;
  logic                  rfl_gnt;
  logic                  lkp_gnt;
  logic                  ram_req;
  logic                  ram_we;
  logic [ADDR_WIDHT-1:0] ram_addr;
  logic [SET_WIDHT-1:0]  ram_data;

`ifdef SARGANTANA_SET_RAM_CTRL_STARVE_GUARD_EN
  assign lkp_first = (starve_q >= LIMIT);
`else
  assign lkp_first = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    done_d   = 1'b0;
    starve_d = starve_q;
    rfl_gnt  = 1'b0;
    lkp_gnt  = 1'b0;
    ram_req  = 1'b0;
    ram_we   = 1'b0;
    ram_addr = '0;
    ram_data = '0;

    case (state_q)
      IDLE: begin
        if (bus.flush_i) begin
          state_d = FLUSH;
        end else if (bus.rfl_valid_i && !(lkp_first && bus.lkp_valid_i)) begin
          rfl_gnt = 1'b1;
        end else if (bus.lkp_valid_i) begin
          lkp_gnt = 1'b1;
        end
      end
      FLUSH: begin
        ram_req  = 1'b1;
        ram_we   = 1'b1;
        ram_addr = cnt_q;
        // counter wraps to 0 naturally after the last entry
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (!rstn_i) begin
      rfl_gnt = 1'b0;
      lkp_gnt = 1'b0;
      ram_req = 1'b0;
      ram_we  = 1'b0;
    end

    if (rfl_gnt) begin
      ram_req  = 1'b1;
      ram_we   = 1'b1;
      ram_addr = bus.rfl_addr_i;
      ram_data = bus.rfl_data_i;
    end else if (lkp_gnt) begin
      ram_req  = 1'b1;
      ram_addr = bus.lkp_addr_i;
    end

    // consecutive refill wins while a lookup is left waiting; saturates
    if (!bus.lkp_valid_i || lkp_gnt) begin
      starve_d = '0;
    end else if (rfl_gnt && (starve_q != LIMIT)) begin
      starve_d = starve_q + 1'b1;
    end

    rvalid_d = lkp_gnt;
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      done_q   <= 1'b0;
      rvalid_q <= 1'b0;
      starve_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      done_q   <= done_d;
      rvalid_q <= rvalid_d;
      starve_q <= starve_d;
    end
  end

  assign bus.lkp_ready_o  = lkp_gnt;
  assign bus.rfl_ready_o  = rfl_gnt;
  assign bus.lkp_rvalid_o = rvalid_q;
  assign bus.flush_busy_o = (state_q == FLUSH);
  assign bus.flush_done_o = done_q;
  assign bus.ram_req_o    = ram_req;
  assign bus.ram_we_o     = ram_we;
  assign bus.ram_addr_o   = ram_addr;
  assign bus.ram_data_o   = ram_data;

endmodule

// File: tb/tb_sargantana_set_ram_ctrl.sv
module tb_sargantana_set_ram_ctrl;
  localparam int SW_W  = 256;
  localparam int AW    = 6;
  localparam int DEPTH = 1 << AW;
  localparam int LIMIT = 4;
`ifdef SARGANTANA_SET_RAM_CTRL_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic clk_i  = 1'b0;
  logic rstn_i = 1'b0;
  always #5 clk_i = ~clk_i;

  sargantana_set_ram_ctrl_if #(.SET_WIDHT(SW_W), .ADDR_WIDHT(AW)) bif ();

  sargantana_set_ram_ctrl #(.SET_WIDHT(SW_W), .ADDR_WIDHT(AW), .STARVE_LIMIT(LIMIT)) dut (
    .clk_i  (clk_i),
    .rstn_i (rstn_i),
    .bus    (bif)
  );

  // behavioural set RAM attached to the controller pins
  logic [SW_W-1:0] tb_mem [DEPTH];
  logic [SW_W-1:0] ram_rdata;
  always @(posedge clk_i) begin
    if (bif.ram_req_o && bif.ram_we_o) tb_mem[bif.ram_addr_o] <= bif.ram_data_o;
    else if (bif.ram_req_o) ram_rdata <= tb_mem[bif.ram_addr_o];
  end

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [SW_W-1:0] act, input logic [SW_W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [SW_W-1:0] rnd256();
    logic [SW_W-1:0] r;
    for (int i = 0; i < SW_W/32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  // ---------------- reference model ----------------
  logic [SW_W-1:0] ref_mem [DEPTH];
  int              m_left   = 0;   // flush writes still to be issued
  bit              m_done   = 0;
  bit              m_rv     = 0;
  int              m_starve = 0;
  logic [SW_W-1:0] m_rdata  = '0;
  bit              m_lkp_gnt = 0, m_rfl_gnt = 0;

  logic            e_lr, e_rr, e_req, e_we, e_busy, e_done, e_rv, n_done, n_rv;
  logic [AW-1:0]   e_addr;
  logic [SW_W-1:0] e_data, e_rd;

  always @(negedge clk_i) begin
    {e_lr, e_rr, e_req, e_we, e_busy, e_done, e_rv} = '0;
    e_addr = '0; e_data = '0; e_rd = m_rdata;
    m_lkp_gnt = 0; m_rfl_gnt = 0;
    if (!rstn_i) begin
      m_left = 0; m_done = 0; m_rv = 0; m_starve = 0;
    end else begin
      e_busy = (m_left != 0);
      e_done = m_done;
      e_rv   = m_rv;
      n_done = 0; n_rv = 0;
      if (m_left != 0) begin
        e_req = 1; e_we = 1;
        e_addr = AW'(DEPTH - m_left);
        ref_mem[e_addr] = '0;
        m_left--;
        n_done = (m_left == 0);
      end else if (bif.flush_i) begin
        m_left = DEPTH;
      end else if (bif.rfl_valid_i &&
                   !(GUARD && m_starve >= LIMIT && bif.lkp_valid_i)) begin
        m_rfl_gnt = 1;
      end else if (bif.lkp_valid_i) begin
        m_lkp_gnt = 1;
      end
      if (m_rfl_gnt) begin
        e_rr = 1; e_req = 1; e_we = 1;
        e_addr = bif.rfl_addr_i; e_data = bif.rfl_data_i;
        ref_mem[e_addr] = e_data;
      end
      if (m_lkp_gnt) begin
        e_lr = 1; e_req = 1;
        e_addr = bif.lkp_addr_i;
        m_rdata = ref_mem[e_addr];
        n_rv = 1;
      end
      if (!bif.lkp_valid_i || m_lkp_gnt) m_starve = 0;
      else if (m_rfl_gnt && m_starve < LIMIT) m_starve++;
      m_done = n_done;
      m_rv   = n_rv;
    end
    chk("lkp_ready", bif.lkp_ready_o, e_lr);
    chk("rfl_ready", bif.rfl_ready_o, e_rr);
    chk("ram_req", bif.ram_req_o, e_req);
    chk("ram_we", bif.ram_we_o, e_we);
    chk("ram_addr", bif.ram_addr_o, e_addr);
    chk("ram_data", bif.ram_data_o, e_data);
    chk("flush_busy", bif.flush_busy_o, e_busy);
    chk("flush_done", bif.flush_done_o, e_done);
    chk("lkp_rvalid", bif.lkp_rvalid_o, e_rv);
    if (rstn_i && e_rv) chk("lkp_rdata", ram_rdata, e_rd);
  end

  // ---------------- stimulus ----------------
  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  task automatic at_neg();
    @(negedge clk_i);
  endtask

  logic [SW_W-1:0] pat_a, pat_b;
  int busy_n, done_n, done_at, lk_n;

  initial begin
    bif.lkp_valid_i = 0; bif.lkp_addr_i = '0;
    bif.rfl_valid_i = 0; bif.rfl_addr_i = '0; bif.rfl_data_i = '0;
    bif.flush_i = 0;
    pat_a = {8{32'hA5A5_0001}};
    pat_b = {8{32'h3C3C_0002}};
    repeat (3) cyc();
    rstn_i = 1;

    // flush sweep, with an extra flush_i pulse in mid-sweep that must be ignored
    cyc(); bif.flush_i = 1;
    at_neg();
    busy_n = 0; done_n = 0; done_at = 0;
    for (int k = 1; k <= 80; k++) begin
      cyc(); bif.flush_i = (k == 11);
      at_neg();
      if (bif.flush_busy_o) busy_n++;
      if (bif.flush_done_o) begin
        done_n++;
        if (done_at == 0) done_at = k;
      end
    end
    chk("flush_busy_cycles", 32'(busy_n), 32'd64);
    chk("flush_done_cycle", 32'(done_at), 32'd65);
    chk("flush_done_count", 32'(done_n), 32'd1);

    // refill addr 5 then lookup addr 5
    cyc(); bif.rfl_valid_i = 1; bif.rfl_addr_i = 6'd5; bif.rfl_data_i = pat_a;
    at_neg(); chk("t1_rfl_ready", bif.rfl_ready_o, 1'b1);
    cyc(); bif.rfl_valid_i = 0; bif.lkp_valid_i = 1; bif.lkp_addr_i = 6'd5;
    at_neg(); chk("t1_lkp_ready", bif.lkp_ready_o, 1'b1);
    cyc(); bif.lkp_valid_i = 0;
    at_neg(); chk("t1_rvalid", bif.lkp_rvalid_o, 1'b1);
    chk("t1_rdata", ram_rdata, pat_a);

    // same-index collision: refill wins, lookup retries and sees the new line
    cyc(); bif.rfl_valid_i = 1; bif.rfl_addr_i = 6'd3; bif.rfl_data_i = pat_b;
    bif.lkp_valid_i = 1; bif.lkp_addr_i = 6'd3;
    at_neg(); chk("t2_rfl_ready", bif.rfl_ready_o, 1'b1);
    chk("t2_lkp_ready0", bif.lkp_ready_o, 1'b0);
    cyc(); bif.rfl_valid_i = 0;
    at_neg(); chk("t2_lkp_ready1", bif.lkp_ready_o, 1'b1);
    cyc(); bif.lkp_valid_i = 0;
    at_neg(); chk("t2_rdata", ram_rdata, pat_b);

    // reset while the flush counter is at 20
    cyc(); bif.flush_i = 1;
    cyc(); bif.flush_i = 0;
    repeat (20) cyc();
    rstn_i = 0;
    at_neg(); chk("t4_busy_in_reset", bif.flush_busy_o, 1'b0);
    cyc(); rstn_i = 1;
    bif.lkp_valid_i = 1; bif.lkp_addr_i = 6'd5;
    at_neg(); chk("t4_lkp_ready", bif.lkp_ready_o, 1'b1);
    cyc(); bif.lkp_valid_i = 0;
    at_neg(); chk("t4_rdata_flushed", ram_rdata, '0);
    done_n = 0; busy_n = 0;
    for (int k = 0; k < 70; k++) begin
      cyc(); at_neg();
      if (bif.flush_done_o) done_n++;
      if (bif.flush_busy_o) busy_n++;
    end
    chk("t4_no_done", 32'(done_n), 32'd0);
    chk("t4_no_busy", 32'(busy_n), 32'd0);

    // continuous refill + lookup contention
    cyc(); bif.lkp_valid_i = 1; bif.lkp_addr_i = 6'd9;
    bif.rfl_valid_i = 1; bif.rfl_addr_i = 6'd7; bif.rfl_data_i = rnd256();
    lk_n = 0;
    for (int k = 0; k < 20; k++) begin
      at_neg();
      if (bif.lkp_ready_o) lk_n++;
      cyc();
      if (m_rfl_gnt) bif.rfl_data_i = rnd256();
    end
    chk("t5_lkp_grants", 32'(lk_n), GUARD ? 32'd4 : 32'd0);
    bif.lkp_valid_i = 0; bif.rfl_valid_i = 0;

    // randomized traffic
    for (int k = 0; k < 4000; k++) begin
      cyc();
      if (bif.lkp_valid_i && m_lkp_gnt) bif.lkp_valid_i = 0;
      if (bif.rfl_valid_i && m_rfl_gnt) bif.rfl_valid_i = 0;
      if (!bif.lkp_valid_i && ($urandom_range(0, 2) == 0)) begin
        bif.lkp_valid_i = 1;
        bif.lkp_addr_i = ($urandom_range(0, 1) == 0) ? AW'($urandom_range(0, 7)) : AW'($urandom);
      end
      if (!bif.rfl_valid_i && ($urandom_range(0, 2) == 0)) begin
        bif.rfl_valid_i = 1;
        bif.rfl_addr_i = ($urandom_range(0, 1) == 0) ? AW'($urandom_range(0, 7)) : AW'($urandom);
        bif.rfl_data_i = rnd256();
      end
      bif.flush_i = ($urandom_range(0, 149) == 0);
      rstn_i = ($urandom_range(0, 399) != 0);
    end
    cyc(); rstn_i = 1;
    bif.lkp_valid_i = 0; bif.rfl_valid_i = 0; bif.flush_i = 0;
    repeat (3) cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
